// File: rtl/alarm_bank_m.sv
// alarm_bank_m: bank of NUM_ALARMS independent alarm channels.
// Each channel holds a setpoint plus an arm/ring/snooze state machine with
// a shared-width countdown timer for ring timeout and snooze.
// Ports:
//   clock, reset_n      - system clock, asynchronous active-low reset
//   counter_state, tick - timestamp and one-cycle "new second" strobe
//   set_flag            - counter being set; blocks matching and countdowns
//   wr_en/idx/time/arm  - per-channel setpoint write (arm or disarm)
//   dismiss, snooze     - global controls applied to all channels
//   ring_vec, armed_vec, snoozed_vec, alarm_state - registered status
module alarm_bank_m #(
    parameter int unsigned NUM_ALARMS  = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned COUNTER_W   = 17,
    parameter int unsigned COUNTER_MAX = 86399,
    parameter int unsigned TIMER_W     = 16,
    parameter int unsigned SNOOZE_SECS = 540,
    parameter int unsigned RING_SECS   = 60
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [COUNTER_W-1:0]  counter_state,
    input  logic                  tick,
    input  logic                  set_flag,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [COUNTER_W-1:0]  wr_time,
    input  logic                  wr_arm,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic [NUM_ALARMS-1:0] ring_vec,
    output logic [NUM_ALARMS-1:0] armed_vec,
    output logic [NUM_ALARMS-1:0] snoozed_vec,
    output logic                  alarm_state
);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_RINGING  = 2'd2,
        S_SNOOZED  = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0]   RING_LOAD   = TIMER_W'(RING_SECS);
    localparam logic [TIMER_W-1:0]   SNOOZE_LOAD = TIMER_W'(SNOOZE_SECS);
    localparam logic [TIMER_W-1:0]   TIMER_ONE   = TIMER_W'(1);
    localparam logic [COUNTER_W-1:0] LAST_TIME   = COUNTER_W'(COUNTER_MAX);
    localparam bit                   RING_TIMED  = (RING_SECS != 0);

    state_t               state_q    [NUM_ALARMS];
    state_t               state_nxt  [NUM_ALARMS];
    logic [COUNTER_W-1:0] setpoint_q [NUM_ALARMS];
    logic [COUNTER_W-1:0] setpoint_nxt [NUM_ALARMS];
    logic [TIMER_W-1:0]   timer_q    [NUM_ALARMS];
    logic [TIMER_W-1:0]   timer_nxt  [NUM_ALARMS];

    logic                  qtick;
    logic                  wr_ok;
    logic [31:0]           wr_sel;
    logic [NUM_ALARMS-1:0] ring_nxt;
    logic [NUM_ALARMS-1:0] armed_nxt;
    logic [NUM_ALARMS-1:0] snoozed_nxt;

    // Ticks only count while the counter is running normally.
    assign qtick  = tick & ~set_flag;
    assign wr_sel = 32'(wr_idx);
    // Out-of-range channel or timestamp discards the write completely.
    assign wr_ok  = wr_en && (wr_sel < NUM_ALARMS) && (wr_time <= LAST_TIME);

    // Next-state for every channel; write > dismiss > snooze > match/timer.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_nxt[i]    = state_q[i];
            setpoint_nxt[i] = setpoint_q[i];
            timer_nxt[i]    = timer_q[i];

            if (wr_ok && (wr_sel == 32'(i))) begin
                timer_nxt[i] = '0;
                if (wr_arm) begin
                    state_nxt[i]    = S_ARMED;
                    setpoint_nxt[i] = wr_time;
                end else begin
                    state_nxt[i]    = S_DISARMED;
                end
            end else begin
                case (state_q[i])
                    S_ARMED: begin
                        if (qtick && (counter_state == setpoint_q[i])) begin
                            state_nxt[i] = S_RINGING;
                            timer_nxt[i] = RING_LOAD;
                        end
                    end
                    S_RINGING: begin
                        if (dismiss) begin
                            state_nxt[i] = S_ARMED;
                        end else if (snooze) begin
                            state_nxt[i] = S_SNOOZED;
                            timer_nxt[i] = SNOOZE_LOAD;
                        end else if (qtick && RING_TIMED) begin
                            if (timer_q[i] == TIMER_ONE) begin
                                state_nxt[i] = S_ARMED;
                            end else begin
                                timer_nxt[i] = timer_q[i] - TIMER_ONE;
                            end
                        end
                    end
                    S_SNOOZED: begin
                        if (dismiss) begin
                            state_nxt[i] = S_ARMED;
                        end else if (qtick) begin
                            if (timer_q[i] == TIMER_ONE) begin
                                state_nxt[i] = S_RINGING;
                                timer_nxt[i] = RING_LOAD;
                            end else begin
                                timer_nxt[i] = timer_q[i] - TIMER_ONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Status decode of the next state so outputs register alongside it.
    always_comb begin
        ring_nxt    = '0;
        armed_nxt   = '0;
        snoozed_nxt = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            ring_nxt[i]    = (state_nxt[i] == S_RINGING);
            armed_nxt[i]   = (state_nxt[i] != S_DISARMED);
            snoozed_nxt[i] = (state_nxt[i] == S_SNOOZED);
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]    <= S_DISARMED;
                setpoint_q[i] <= '0;
                timer_q[i]    <= '0;
            end
            ring_vec    <= '0;
            armed_vec   <= '0;
            snoozed_vec <= '0;
            alarm_state <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]    <= state_nxt[i];
                setpoint_q[i] <= setpoint_nxt[i];
                timer_q[i]    <= timer_nxt[i];
            end
            ring_vec    <= ring_nxt;
            armed_vec   <= armed_nxt;
            snoozed_vec <= snoozed_nxt;
            alarm_state <= |ring_nxt;
        end
    end

endmodule

// File: tb/tb_alarm_bank_m.sv
// tb_alarm_bank_m: directed table of one-cycle vectors for alarm_bank_m
// (RING_SECS=3, SNOOZE_SECS=5, IDX_W=3 so out-of-range indices can be
// driven), plus hand-written async-reset sequences.
module tb_alarm_bank_m;

    localparam int unsigned NA = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 17;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CW-1:0] counter_state;
    logic          tick, set_flag, wr_en, wr_arm, dismiss, snooze;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] wr_time;
    logic [NA-1:0] ring_vec, armed_vec, snoozed_vec;
    logic          alarm_state;

    int tests  = 0;
    int fails  = 0;

    alarm_bank_m #(
        .NUM_ALARMS (NA),
        .IDX_W      (IW),
        .COUNTER_W  (CW),
        .COUNTER_MAX(86399),
        .TIMER_W    (16),
        .SNOOZE_SECS(5),
        .RING_SECS  (3)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .counter_state(counter_state),
        .tick         (tick),
        .set_flag     (set_flag),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_time      (wr_time),
        .wr_arm       (wr_arm),
        .dismiss      (dismiss),
        .snooze       (snooze),
        .ring_vec     (ring_vec),
        .armed_vec    (armed_vec),
        .snoozed_vec  (snoozed_vec),
        .alarm_state  (alarm_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          we;
        logic [IW-1:0] wi;
        logic [CW-1:0] wt;
        logic          wa;
        logic [CW-1:0] ct;
        logic          tk;
        logic          sf;
        logic          dm;
        logic          sz;
        logic [NA-1:0] r;
        logic [NA-1:0] a;
        logic [NA-1:0] s;
        logic          al;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input int wi, input int wt, input logic wa,
                       input int ct, input logic tk, input logic sf,
                       input logic dm, input logic sz,
                       input logic [NA-1:0] r, input logic [NA-1:0] a,
                       input logic [NA-1:0] s, input logic al);
        vec_t v;
        v.we = we; v.wi = IW'(wi); v.wt = CW'(wt); v.wa = wa;
        v.ct = CW'(ct); v.tk = tk; v.sf = sf; v.dm = dm; v.sz = sz;
        v.r = r; v.a = a; v.s = s; v.al = al;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [NA-1:0] act, input logic [NA-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_idx = '0; wr_time = '0; wr_arm = 1'b0;
        tick = 1'b0; set_flag = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    endtask

    initial begin
        // Row fields: we wi wt wa | ct tk sf dm sz | ring armed snoozed alarm
        // Match on ch1 and 3-tick auto-dismiss.
        add(1, 1, 34961, 1,  34958, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 0);
        add(0, 0, 0, 0,      34959, 1, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 0);
        add(0, 0, 0, 0,      34960, 1, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 0);
        add(0, 0, 0, 0,      34961, 1, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1);
        add(0, 0, 0, 0,      34961, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1);
        add(0, 0, 0, 0,      34962, 1, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1);
        add(0, 0, 0, 0,      34963, 1, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1);
        add(0, 0, 0, 0,      34964, 1, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 0);
        // Set suppression on ch0.
        add(1, 0, 50925, 1,  34964, 0, 0, 0, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        add(0, 0, 0, 0,      50925, 1, 1, 0, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        add(0, 0, 0, 0,      50925, 1, 1, 0, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        add(0, 0, 0, 0,      50925, 1, 1, 0, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        add(0, 0, 0, 0,      50926, 1, 0, 0, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        add(0, 0, 0, 0,      50927, 1, 0, 0, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        add(0, 0, 0, 0,      50924, 1, 1, 0, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        add(0, 0, 0, 0,      50925, 1, 0, 0, 0, 4'b0001, 4'b0011, 4'b0000, 1);
        add(0, 0, 0, 0,      50925, 0, 0, 1, 0, 4'b0000, 4'b0011, 4'b0000, 0);
        // Snooze on ch2, set_flag ticks not counted, dismiss from snooze.
        add(1, 2, 1000, 1,   50925, 0, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        add(0, 0, 0, 0,      1000, 1, 0, 0, 0, 4'b0100, 4'b0111, 4'b0000, 1);
        add(0, 0, 0, 0,      1000, 0, 0, 0, 1, 4'b0000, 4'b0111, 4'b0100, 0);
        add(0, 0, 0, 0,      1001, 1, 0, 0, 0, 4'b0000, 4'b0111, 4'b0100, 0);
        add(0, 0, 0, 0,      1002, 1, 1, 0, 0, 4'b0000, 4'b0111, 4'b0100, 0);
        add(0, 0, 0, 0,      1002, 1, 0, 0, 0, 4'b0000, 4'b0111, 4'b0100, 0);
        add(0, 0, 0, 0,      1003, 1, 0, 0, 0, 4'b0000, 4'b0111, 4'b0100, 0);
        add(0, 0, 0, 0,      1004, 1, 0, 0, 0, 4'b0000, 4'b0111, 4'b0100, 0);
        add(0, 0, 0, 0,      1005, 1, 0, 0, 0, 4'b0100, 4'b0111, 4'b0000, 1);
        add(0, 0, 0, 0,      1005, 0, 0, 0, 1, 4'b0000, 4'b0111, 4'b0100, 0);
        add(0, 0, 0, 0,      1005, 0, 0, 1, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        for (int t = 1006; t <= 1010; t++)
            add(0, 0, 0, 0,  t,    1, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        // Priority: dismiss+snooze together, write vs match, discarded writes.
        add(1, 3, 2000, 1,   1010, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        add(0, 0, 0, 0,      2000, 1, 0, 0, 0, 4'b1000, 4'b1111, 4'b0000, 1);
        add(0, 0, 0, 0,      2000, 0, 0, 1, 1, 4'b0000, 4'b1111, 4'b0000, 0);
        add(1, 3, 2000, 0,   2000, 1, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        add(1, 5, 0, 0,      2000, 0, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        add(1, 3, 86400, 1,  2000, 0, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        // A write cancels an active ring.
        add(0, 0, 0, 0,      1000, 1, 0, 0, 0, 4'b0100, 4'b0111, 4'b0000, 1);
        add(1, 2, 86397, 1,  1000, 0, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        // Wrap: ch0/ch3 at 0 ring together, ch2 snooze spans midnight.
        add(1, 0, 0, 1,      1000, 0, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 0);
        add(1, 3, 0, 1,      1000, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        add(0, 0, 0, 0,      86397, 1, 0, 0, 0, 4'b0100, 4'b1111, 4'b0000, 1);
        add(0, 0, 0, 0,      86397, 0, 0, 0, 1, 4'b0000, 4'b1111, 4'b0100, 0);
        add(0, 0, 0, 0,      86398, 1, 0, 0, 0, 4'b0000, 4'b1111, 4'b0100, 0);
        add(0, 0, 0, 0,      86399, 1, 0, 0, 0, 4'b0000, 4'b1111, 4'b0100, 0);
        add(0, 0, 0, 0,      0,     1, 0, 0, 0, 4'b1001, 4'b1111, 4'b0100, 1);
        add(0, 0, 0, 0,      1,     1, 0, 0, 0, 4'b1001, 4'b1111, 4'b0100, 1);
        add(0, 0, 0, 0,      2,     1, 0, 0, 0, 4'b1101, 4'b1111, 4'b0000, 1);
        add(0, 0, 0, 0,      3,     1, 0, 0, 0, 4'b0100, 4'b1111, 4'b0000, 1);
        add(0, 0, 0, 0,      3,     0, 0, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);

        // Reset state.
        reset_n = 1'b0;
        counter_state = '0;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        check("reset_ring",    -1, ring_vec,    '0);
        check("reset_armed",   -1, armed_vec,   '0);
        check("reset_snoozed", -1, snoozed_vec, '0);
        check("reset_alarm",   -1, {3'b000, alarm_state}, '0);
        reset_n = 1'b1;

        // Table: inputs held for one clock, outputs sampled 1 time unit later.
        for (int i = 0; i < vecs.size(); i++) begin
            wr_en = vecs[i].we; wr_idx = vecs[i].wi; wr_time = vecs[i].wt;
            wr_arm = vecs[i].wa; counter_state = vecs[i].ct; tick = vecs[i].tk;
            set_flag = vecs[i].sf; dismiss = vecs[i].dm; snooze = vecs[i].sz;
            @(posedge clock);
            #1;
            check("ring_vec",    i, ring_vec,    vecs[i].r);
            check("armed_vec",   i, armed_vec,   vecs[i].a);
            check("snoozed_vec", i, snoozed_vec, vecs[i].s);
            check("alarm_state", i, {3'b000, alarm_state}, {3'b000, vecs[i].al});
        end

        // Async reset mid-ring: ch2 (setpoint 86397) rings, then reset mid-cycle.
        idle_inputs();
        counter_state = CW'(86397);
        tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
        check("pre_reset_ring", 100, ring_vec, 4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_ring",    101, ring_vec,    '0);
        check("async_armed",   101, armed_vec,   '0);
        check("async_snoozed", 101, snoozed_vec, '0);
        check("async_alarm",   101, {3'b000, alarm_state}, '0);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_reset_armed", 102, armed_vec, '0);
        // Setpoints were cleared and channels disarmed: a former match stays quiet.
        tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
        check("post_reset_ring", 103, ring_vec, '0);

        // Reset while snoozed: ch1 armed 500, ring, snooze, then reset.
        wr_en = 1'b1; wr_idx = IW'(1); wr_time = CW'(500); wr_arm = 1'b1;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        counter_state = CW'(500); tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0; snooze = 1'b1;
        @(posedge clock);
        #1;
        snooze = 1'b0;
        check("pre_reset_snoozed", 104, snoozed_vec, 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_snoozed2", 105, snoozed_vec, '0);
        check("async_armed2",   105, armed_vec,   '0);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_bank_m.md
Name: alarm_bank_m

Overview:
Multi-channel successor to the single alarm block. It holds NUM_ALARMS independent alarm setpoints, each with its own arm/ring/snooze state machine, ring timeout and snooze countdown. It sits beside the counter module, consuming its timestamp and a per-second tick, and drives alarm status to the output module. The same "set-flag suppresses match" semantics are kept, now clocked and resettable.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..16)
IDX_W, 2, width of wr_idx; 2**IDX_W >= NUM_ALARMS
COUNTER_W, 17, timestamp width
COUNTER_MAX, 86399, last valid timestamp (seconds/day - 1)
TIMER_W, 16, width of per-channel countdown timers
SNOOZE_SECS, 540, ticks from snooze until re-ring (1..2**TIMER_W-1)
RING_SECS, 60, ticks of ringing before auto-dismiss; 0 = ring until dismissed

Ports:
clock  in  1  system clock, all state on posedge
reset_n  in  1  asynchronous active-low reset
counter_state  in  COUNTER_W  current timestamp from counter module
tick  in  1  one-cycle strobe, high in the cycle counter_state holds a newly advanced second
set_flag  in  1  counter being set; suppresses matching and timer advance
wr_en  in  1  write strobe for one channel
wr_idx  in  IDX_W  channel to write
wr_time  in  COUNTER_W  setpoint to write
wr_arm  in  1  1 = arm channel with wr_time, 0 = disarm
dismiss  in  1  dismiss all RINGING and SNOOZED channels
snooze  in  1  snooze all RINGING channels
ring_vec  out  NUM_ALARMS  per-channel ringing
armed_vec  out  NUM_ALARMS  per-channel armed (ARMED, RINGING or SNOOZED)
snoozed_vec  out  NUM_ALARMS  per-channel snoozed
alarm_state  out  1  OR of ring_vec

Behaviour:
- Reset (reset_n low, async): every channel DISARMED, setpoint 0, timer 0; all outputs 0. Takes effect immediately, mid-ring/mid-snooze included.
- qtick = tick & ~set_flag. All matching and timer decrements use qtick only.
- Per-channel states: DISARMED, ARMED, RINGING, SNOOZED.
- DISARMED -> ARMED: write with wr_arm=1 (setpoint := wr_time).
- ARMED -> RINGING: qtick & counter_state == setpoint; timer := RING_SECS.
- RINGING -> ARMED: dismiss; or RING_SECS != 0 and qtick with timer == 1 (auto-dismiss).
- RINGING -> SNOOZED: snooze & ~dismiss; timer := SNOOZE_SECS.
- SNOOZED -> RINGING: qtick with timer == 1; timer := RING_SECS.
- SNOOZED -> ARMED: dismiss.
- In RINGING/SNOOZED, each qtick decrements timer; setpoint matches are ignored. RING_SECS=0: no decrement in RINGING.
- Any write to a channel overrides its state at that edge: wr_arm=1 -> ARMED with new setpoint (cancels ring/snooze); wr_arm=0 -> DISARMED.
- Write priority on the written channel: write > dismiss > snooze > match/timer. Other channels are unaffected by the write.
- Writes with wr_idx >= NUM_ALARMS, or wr_time > COUNTER_MAX, are discarded entirely.
- snooze in ARMED/SNOOZED/DISARMED: no effect. dismiss in ARMED/DISARMED: no effect.
- Latency: all outputs registered. State change is visible the cycle after the causing input edge, e.g. ring_vec rises one clock after the matching qtick. alarm_state is the registered OR of ring_vec (same cycle as ring_vec).
- Set-flag edge case: while set_flag is high nothing matches. Setting the counter to T while armed at T does not ring, because the next qtick presents T+1. Setting to T-1 does ring on the next qtick.
- Wrap-around: setpoint 0 matches on the COUNTER_MAX->0 rollover tick. The snooze is tick-counted, so it spans midnight without special handling.
- Multiple channels may ring simultaneously. Two channels with the same setpoint both ring on the same qtick.

Test Plan:
- Reset: write ch0 arm 100, drive to ring, assert reset_n=0 mid-ring -> all outputs 0 immediately; armed_vec=0 after release.
- Match: ch1 armed 34961, ticks 34959..34961 -> ring_vec=4'b0010 and alarm_state=1 one clock after the 34961 tick. With RING_SECS=3, ring_vec returns to 0 after 3 further qticks; armed_vec[1] stays 1.
- Set suppression: ch0 armed 50925; set_flag high holding 50925 for 10 ticks, release, ticks 50926.. -> no ring. Repeat with set to 50924 -> ring on tick 50925.
- Snooze: ch2 ringing, pulse snooze -> snoozed_vec=4'b0100, ring_vec=0. With SNOOZE_SECS=5, ring again after 5 qticks; ticks during set_flag do not count. Dismiss while snoozed -> ARMED, no re-ring.
- Priority/simultaneity: same cycle dismiss+snooze on ringing ch3 -> ARMED. Write ch3 wr_arm=0 in the same cycle as its matching tick -> DISARMED, no ring. Write with wr_idx=5 (NUM_ALARMS=4) or wr_time=86400 -> no state change.
- Wrap: ch0 armed 0, counter 86398->86399->0 -> ring on the 0 tick. Snooze at 86397 with SNOOZE_SECS=5 -> re-ring at counter 2.
